// File: rtl/dma_engineer_arbiter_pkg.sv
// Shared definitions for the DMA engine arbiter.
// Contents:
//   state_t     - arbiter FSM states (IDLE, REQ, XFER)
//   DEF_ADDR_W  - default width of the start-address and length fields
//   DEF_DATA_W  - default width of the DMA data path
package dma_engineer_arbiter_pkg;

    localparam int DEF_ADDR_W = 27;
    localparam int DEF_DATA_W = 512;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

endpackage

// File: rtl/dma_engineer_arbiter_rr_pick.sv
// Combinational round-robin selector.
// Picks the first set bit of req at or after ptr, wrapping modulo NUM_REQ.
// Ports:
//   req   [NUM_REQ-1:0]  request vector
//   ptr   [ID_W-1:0]     search start position (must be < NUM_REQ)
//   valid                at least one request bit is set
//   idx   [ID_W-1:0]     selected index (0 when valid is low)
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               valid,
    output logic [ID_W-1:0]    idx
);

    int          pos;
    logic [ID_W-1:0] pos_w;

    // Scan from the farthest offset to the nearest so that the nearest
    // set bit (relative to ptr) is the last one written and therefore wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = 0;
        pos_w = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            pos = int'(ptr) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            pos_w = ID_W'(pos);
            if (req[pos_w]) begin
                valid = 1'b1;
                idx   = pos_w;
            end
        end
    end

endmodule

// File: rtl/dma_engineer_arbiter.sv
// Round-robin arbiter sharing one DMA weight-fetch engine among NUM_REQ
// layer controllers. One requester is granted at a time; its start address
// and length are latched and forwarded to the engine, and the engine's data
// strobes are steered back to that requester only. Data is broadcast.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_req                  per-requester request level
//   req_start_addr/length    packed per-requester address/length (i*ADDR_W +: ADDR_W)
//   req_ack                  one-cycle acknowledge to the granted requester
//   req_dout_en/eop          steered data-valid / last-beat strobes
//   req_dout                 registered engine data, broadcast
//   dma_engineer_*           request/ack/address/length/data to and from the engine
//   busy                     FSM in REQ or XFER
//   grant_id                 current or most recent grant index
//   err_stray                sticky: engine beat seen while IDLE
// All outputs are registered.
module dma_engineer_arbiter
    import dma_engineer_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_start_addr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_length,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [NUM_REQ-1:0]        req_dout_en,
    output logic [NUM_REQ-1:0]        req_dout_eop,
    output logic [DATA_W-1:0]         req_dout,
    output logic                      dma_engineer_req,
    input  logic                      dma_engineer_ack,
    output logic [ADDR_W-1:0]         dma_engineer_start_addr,
    output logic [ADDR_W-1:0]         dma_engineer_length,
    input  logic                      dma_engineer_dout_en,
    input  logic                      dma_engineer_dout_eop,
    input  logic [DATA_W-1:0]         dma_engineer_dout,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      err_stray
);

    state_t          state_reg;
    state_t          state_next;
    logic [ID_W-1:0] rr_ptr_reg;
    logic [ID_W-1:0] rr_ptr_next;
    logic            pick_valid;
    logic [ID_W-1:0] pick_idx;
    logic            beat_last;

    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [ADDR_W-1:0] len_arr  [NUM_REQ];

    // Unpack the per-requester address/length fields.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_start_addr[gi*ADDR_W +: ADDR_W];
            assign len_arr[gi]  = req_length[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req   (req_req),
        .ptr   (rr_ptr_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // eop is only meaningful when qualified by dout_en.
    assign beat_last = dma_engineer_dout_en & dma_engineer_dout_eop;

    // Pointer moves just past the requester whose grant is ending.
    assign rr_ptr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                // A one-beat transfer may finish in the very ack cycle.
                if (dma_engineer_ack) begin
                    state_next = beat_last ? ST_IDLE : ST_XFER;
                end
            end
            ST_XFER: begin
                if (beat_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg               <= ST_IDLE;
            rr_ptr_reg              <= '0;
            grant_id                <= '0;
            dma_engineer_req        <= 1'b0;
            dma_engineer_start_addr <= '0;
            dma_engineer_length     <= '0;
            req_ack                 <= '0;
            req_dout_en             <= '0;
            req_dout_eop            <= '0;
            req_dout                <= '0;
            busy                    <= 1'b0;
            err_stray               <= 1'b0;
        end else begin
            state_reg        <= state_next;
            // Request and busy track the next state so they line up with it.
            dma_engineer_req <= (state_next == ST_REQ);
            busy             <= (state_next != ST_IDLE);
            req_dout         <= dma_engineer_dout;

            req_ack      <= '0;
            req_dout_en  <= '0;
            req_dout_eop <= '0;

            if (state_reg == ST_IDLE) begin
                if (pick_valid) begin
                    grant_id                <= pick_idx;
                    dma_engineer_start_addr <= addr_arr[pick_idx];
                    dma_engineer_length     <= len_arr[pick_idx];
                end
                // Beats with no grant are dropped and flagged.
                if (dma_engineer_dout_en) begin
                    err_stray <= 1'b1;
                end
            end else begin
                // Grant is committed: steer beats regardless of req_req.
                req_dout_en[grant_id]  <= dma_engineer_dout_en;
                req_dout_eop[grant_id] <= beat_last;
            end

            if ((state_reg == ST_REQ) && dma_engineer_ack) begin
                req_ack[grant_id] <= 1'b1;
            end

            if ((state_reg != ST_IDLE) && (state_next == ST_IDLE)) begin
                rr_ptr_reg <= rr_ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_dma_engineer_arbiter.sv
module tb_dma_engineer_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int ADDR_W  = 27;
    localparam int DATA_W  = 512;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_req;
    logic [NUM_REQ*ADDR_W-1:0] req_start_addr;
    logic [NUM_REQ*ADDR_W-1:0] req_length;
    logic [NUM_REQ-1:0]        req_ack;
    logic [NUM_REQ-1:0]        req_dout_en;
    logic [NUM_REQ-1:0]        req_dout_eop;
    logic [DATA_W-1:0]         req_dout;
    logic                      dma_engineer_req;
    logic                      dma_engineer_ack;
    logic [ADDR_W-1:0]         dma_engineer_start_addr;
    logic [ADDR_W-1:0]         dma_engineer_length;
    logic                      dma_engineer_dout_en;
    logic                      dma_engineer_dout_eop;
    logic [DATA_W-1:0]         dma_engineer_dout;
    logic                      busy;
    logic [ID_W-1:0]           grant_id;
    logic                      err_stray;

    dma_engineer_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .req_req                 (req_req),
        .req_start_addr          (req_start_addr),
        .req_length              (req_length),
        .req_ack                 (req_ack),
        .req_dout_en             (req_dout_en),
        .req_dout_eop            (req_dout_eop),
        .req_dout                (req_dout),
        .dma_engineer_req        (dma_engineer_req),
        .dma_engineer_ack        (dma_engineer_ack),
        .dma_engineer_start_addr (dma_engineer_start_addr),
        .dma_engineer_length     (dma_engineer_length),
        .dma_engineer_dout_en    (dma_engineer_dout_en),
        .dma_engineer_dout_eop   (dma_engineer_dout_eop),
        .dma_engineer_dout       (dma_engineer_dout),
        .busy                    (busy),
        .grant_id                (grant_id),
        .err_stray               (err_stray)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              id;
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] len;
    } grant_exp_t;

    typedef struct {
        int              id;
        logic            eop;
        logic [DATA_W-1:0] data;
    } beat_exp_t;

    grant_exp_t grant_q[$];
    int         ack_q[$];
    beat_exp_t  beat_q[$];

    int total_checks  = 0;
    int failed_checks = 0;
    int en_cnt  [NUM_REQ];
    int eop_cnt [NUM_REQ];
    logic prev_dreq = 1'b0;

    logic [ADDR_W-1:0] addr_tab [NUM_REQ];
    logic [ADDR_W-1:0] len_tab  [NUM_REQ];

    function automatic void check(input string name, input logic [DATA_W-1:0] act,
                                  input logic [DATA_W-1:0] exp);
        total_checks++;
        if (act !== exp) begin
            failed_checks++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int id);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a grant, ack or beat.
    always @(negedge clk) begin
        if (rst) begin
            prev_dreq = 1'b0;
        end else begin
            if (dma_engineer_req && !prev_dreq) begin
                if (grant_q.size() == 0) begin
                    check("unexpected_grant", 1, 0);
                end else begin
                    grant_exp_t g;
                    g = grant_q.pop_front();
                    check("grant_id", DATA_W'(grant_id), DATA_W'(g.id));
                    check("start_addr", DATA_W'(dma_engineer_start_addr), DATA_W'(g.addr));
                    check("length", DATA_W'(dma_engineer_length), DATA_W'(g.len));
                    $display("grant id=%0d addr=%0d len=%0d", grant_id,
                             dma_engineer_start_addr, dma_engineer_length);
                end
            end
            prev_dreq = dma_engineer_req;
            if (req_ack != '0) begin
                if (ack_q.size() == 0) begin
                    check("unexpected_ack", DATA_W'(req_ack), 0);
                end else begin
                    int a;
                    a = ack_q.pop_front();
                    check("req_ack", DATA_W'(req_ack), DATA_W'(onehot(a)));
                    $display("ack id=%0d vec=%b", a, req_ack);
                end
            end
            if ((req_dout_en != '0) || (req_dout_eop != '0)) begin
                if (beat_q.size() == 0) begin
                    check("unexpected_beat", DATA_W'(req_dout_en), 0);
                end else begin
                    beat_exp_t b;
                    b = beat_q.pop_front();
                    check("dout_en", DATA_W'(req_dout_en), DATA_W'(onehot(b.id)));
                    check("dout_eop", DATA_W'(req_dout_eop),
                          b.eop ? DATA_W'(onehot(b.id)) : '0);
                    check("dout_data", req_dout, b.data);
                    $display("beat id=%0d en=%b eop=%b data=%0h", b.id, req_dout_en,
                             req_dout_eop, req_dout[31:0]);
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_dout_en[i])  en_cnt[i]++;
                if (req_dout_eop[i]) eop_cnt[i]++;
            end
        end
    end

    task automatic drive_beat(input int id, input int b, input logic last);
        beat_exp_t e;
        logic [31:0] word;
        word = 32'((id << 16) + b + 32'h1000_0000);
        dma_engineer_dout_en  = 1'b1;
        dma_engineer_dout_eop = last;
        dma_engineer_dout     = {16{word}};
        e.id   = id;
        e.eop  = last;
        e.data = {16{word}};
        beat_q.push_back(e);
    endtask

    // One engine transaction: expect a grant of 'id', ack after ack_dly cycles,
    // then nbeats beats. 'same' puts ack and the single eop beat in one cycle.
    // stop_after > 0 ends early after that many beats (for the reset test).
    task automatic do_xfer(input int id, input int nbeats, input logic same,
                           input logic [NUM_REQ-1:0] req_after, input int ack_dly,
                           input int stop_after);
        grant_exp_t g;
        bit seen;
        seen   = 1'b0;
        g.id   = id;
        g.addr = addr_tab[id];
        g.len  = len_tab[id];
        grant_q.push_back(g);
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (dma_engineer_req) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check("grant_timeout", 0, 1);
            void'(grant_q.pop_back());
            req_req = req_after;
            return;
        end
        req_req = req_after;
        repeat (ack_dly) @(posedge clk);
        @(posedge clk); #1;
        dma_engineer_ack = 1'b1;
        ack_q.push_back(id);
        if (same) drive_beat(id, 0, 1'b1);
        @(posedge clk); #1;
        dma_engineer_ack      = 1'b0;
        dma_engineer_dout_en  = 1'b0;
        dma_engineer_dout_eop = 1'b0;
        if (!same) begin
            for (int b = 0; b < nbeats; b++) begin
                drive_beat(id, b, (b == nbeats - 1));
                @(posedge clk); #1;
                dma_engineer_dout_en  = 1'b0;
                dma_engineer_dout_eop = 1'b0;
                if ((stop_after > 0) && (b + 1 == stop_after)) begin
                    @(negedge clk);
                    return;
                end
            end
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NUM_REQ; i++) begin
            en_cnt[i]  = 0;
            eop_cnt[i] = 0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dma_req"},  DATA_W'(dma_engineer_req), 0);
        check({tag, "_busy"},     DATA_W'(busy), 0);
        check({tag, "_grant_id"}, DATA_W'(grant_id), 0);
        check({tag, "_ack"},      DATA_W'(req_ack), 0);
        check({tag, "_dout_en"},  DATA_W'(req_dout_en), 0);
        check({tag, "_dout_eop"}, DATA_W'(req_dout_eop), 0);
        check({tag, "_dout"},     req_dout, 0);
        check({tag, "_addr"},     DATA_W'(dma_engineer_start_addr), 0);
        check({tag, "_len"},      DATA_W'(dma_engineer_length), 0);
        check({tag, "_err"},      DATA_W'(err_stray), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        addr_tab[0] = 27'd100;  len_tab[0] = 27'd3;
        addr_tab[1] = 27'd2000; len_tab[1] = 27'd1;
        addr_tab[2] = 27'd452;  len_tab[2] = 27'd50;
        addr_tab[3] = 27'd7777; len_tab[3] = 27'd3;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_start_addr[i*ADDR_W +: ADDR_W] = addr_tab[i];
            req_length[i*ADDR_W +: ADDR_W]     = len_tab[i];
        end
        clear_counts();
        rst                   = 1'b1;
        req_req               = '0;
        dma_engineer_ack      = 1'b0;
        dma_engineer_dout_en  = 1'b0;
        dma_engineer_dout_eop = 1'b0;
        dma_engineer_dout     = {16{32'hdead_beef}};
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Round-robin fairness: all four held, order 0,1,2,3,0.
        @(posedge clk); #1;
        req_req = 4'b1111;
        do_xfer(0, 3, 1'b0, 4'b1111, 0, 0);
        do_xfer(1, 3, 1'b0, 4'b1111, 0, 0);
        do_xfer(2, 3, 1'b0, 4'b1111, 0, 0);
        do_xfer(3, 3, 1'b0, 4'b1111, 0, 0);
        do_xfer(0, 3, 1'b0, 4'b0000, 0, 0);
        repeat (3) @(posedge clk);

        // Single request on 2; request dropped before ack (committed grant).
        @(negedge clk);
        clear_counts();
        req_req = 4'b0100;
        do_xfer(2, 50, 1'b0, 4'b0000, 3, 0);
        repeat (3) @(negedge clk);
        check("single_en_cnt2",  DATA_W'(en_cnt[2]), 50);
        check("single_eop_cnt2", DATA_W'(eop_cnt[2]), 1);
        check("single_en_other", DATA_W'(en_cnt[0] + en_cnt[1] + en_cnt[3]), 0);

        // Wrap: pointer now 3, requests 3 and 0 -> grants 3 then 0.
        req_req = 4'b1001;
        do_xfer(3, 3, 1'b0, 4'b1001, 1, 0);
        do_xfer(0, 3, 1'b0, 4'b0000, 1, 0);
        repeat (3) @(negedge clk);

        // Ack and eop together on a one-beat transfer for requester 1.
        req_req = 4'b0010;
        do_xfer(1, 1, 1'b1, 4'b0000, 0, 0);
        @(negedge clk);
        check("same_ack",  DATA_W'(req_ack), DATA_W'(4'b0010));
        check("same_eop",  DATA_W'(req_dout_eop), DATA_W'(4'b0010));
        check("same_idle", DATA_W'(busy), 0);
        repeat (2) @(negedge clk);
        check("same_no_req", DATA_W'(dma_engineer_req), 0);

        // Stray beat while idle.
        check("pre_stray_err", DATA_W'(err_stray), 0);
        @(posedge clk); #1;
        dma_engineer_dout_en  = 1'b1;
        dma_engineer_dout_eop = 1'b1;
        @(posedge clk); #1;
        dma_engineer_dout_en  = 1'b0;
        dma_engineer_dout_eop = 1'b0;
        @(negedge clk);
        check("stray_en",  DATA_W'(req_dout_en), 0);
        check("stray_err", DATA_W'(err_stray), 1);
        repeat (5) @(negedge clk);
        check("stray_sticky", DATA_W'(err_stray), 1);

        // Reset after 10 of 50 beats; pointer was 2 before reset.
        req_req = 4'b0100;
        do_xfer(2, 50, 1'b0, 4'b0000, 0, 10);
        check("mid_busy", DATA_W'(busy), 1);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        req_req = 4'b1111;
        do_xfer(0, 2, 1'b0, 4'b0000, 0, 0);
        repeat (4) @(negedge clk);

        check("grant_q_empty", DATA_W'(grant_q.size()), 0);
        check("ack_q_empty",   DATA_W'(ack_q.size()), 0);
        check("beat_q_empty",  DATA_W'(beat_q.size()), 0);

        $display("%0d/%0d checks passed", total_checks - failed_checks, total_checks);
        $finish;
    end

endmodule
